// File: rtl/uart_pkg.sv
// Shared state encoding, word bit positions and prescale codes for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int EN_SAMPLER = 3;
  localparam int EN_START   = 2;
  localparam int EN_PARITY  = 1;
  localparam int EN_STOP    = 0;

  localparam int ERR_START  = 2;
  localparam int ERR_PARITY = 1;
  localparam int ERR_STOP   = 0;

  localparam logic [1:0] PRESCALE_NONE = 2'b00;
  localparam logic [1:0] PRESCALE_X8   = 2'b01;
  localparam logic [1:0] PRESCALE_X16  = 2'b10;
  localparam logic [1:0] PRESCALE_X32  = 2'b11;

  function automatic int unsigned prescale_ticks(input logic [1:0] code);
    int unsigned n;
    n = 1;
    case (code)
      PRESCALE_NONE: n = 1;
      PRESCALE_X8:   n = 8;
      PRESCALE_X16:  n = 16;
      PRESCALE_X32:  n = 32;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] enable_word(input rx_state_e st);
    logic [3:0] w;
    w = '0;
    case (st)
      ST_START:  begin w[EN_SAMPLER] = 1'b1; w[EN_START]  = 1'b1; end
      ST_DATA:   w[EN_SAMPLER] = 1'b1;
      ST_PARITY: begin w[EN_SAMPLER] = 1'b1; w[EN_PARITY] = 1'b1; end
      ST_STOP:   begin w[EN_SAMPLER] = 1'b1; w[EN_STOP]   = 1'b1; end
      default:   w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Line synchronizer, falling-edge detect and bit-value selection (single sample or
// majority of the last three synchronized samples).
module uart_rx_bit_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic sample_one_i,
  input  logic sample_three_i,
  output logic fall_o,
  output logic sample_o,
  output logic strobe_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist_q;
  logic                   rx_s;
  logic                   majority;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      hist_q <= {hist_q[1:0], rx_s};
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign fall_o   = hist_q[0] & ~rx_s;
  assign majority = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  // The three-sample vote takes priority when both strobes arrive together.
  assign sample_o = sample_three_i ? majority : rx_s;
  assign strobe_o = sample_one_i | sample_three_i;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start-edge qualification, LSB-first deserializer,
// error capture and result pulses. Parity support is compiled in by UART_RX_PARITY_EN.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       BIT_TICK,
  input  logic       sample_one_bit,
  input  logic       sample_three_bit,
  input  logic [2:0] error_flag_word,
  output logic [3:0] block_enable_word,
  output logic       start_bit,
  output logic       parity_bit,
  output logic       stop_bit,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error
);

  logic       fall, sample, strobe;
  rx_state_e  state_q, state_d, tag_state_q;
  logic       tag_strobe_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] data_q;
  logic [3:0] en_q;
  logic       start_bit_q, parity_bit_q, stop_bit_q;
  logic       valid_q, perr_q, ferr_q, stop_err_q;
  logic       tag_live, start_hit, stop_hit, par_flag, goto_parity;

  uart_rx_bit_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk            (clk),
    .rst            (rst),
    .rx_i           (rx_in),
    .sample_one_i   (sample_one_bit),
    .sample_three_i (sample_three_bit),
    .fall_o         (fall),
    .sample_o       (sample),
    .strobe_o       (strobe)
  );

  // error_flag_word answers last cycle's strobe, so match it against the registered
  // tag rather than the live state, which may already have moved on.
  assign tag_live  = tag_strobe_q && (state_q != ST_IDLE);
  assign start_hit = tag_live && (tag_state_q == ST_START) && error_flag_word[ERR_START];
  assign stop_hit  = tag_live && (tag_state_q == ST_STOP)  && error_flag_word[ERR_STOP];

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_hit;
  assign par_hit     = tag_live && (tag_state_q == ST_PARITY) && error_flag_word[ERR_PARITY];
  assign par_flag    = par_err_q | par_hit;
  assign goto_parity = par_en;
`else
  logic unused_parity;
  assign unused_parity = par_en | error_flag_word[ERR_PARITY];
  assign par_flag      = 1'b0;
  assign goto_parity   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall) state_d = ST_START;
      ST_START:  if (BIT_TICK) state_d = ST_DATA;
      ST_DATA:   if (BIT_TICK && bit_cnt_q == 3'd7) state_d = goto_parity ? ST_PARITY : ST_STOP;
      ST_PARITY: if (BIT_TICK) state_d = ST_STOP;
      ST_STOP:   if (BIT_TICK) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (start_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_state_q  <= ST_IDLE;
      tag_strobe_q <= 1'b0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      en_q         <= '0;
      start_bit_q  <= 1'b1;
      parity_bit_q <= 1'b0;
      stop_bit_q   <= 1'b1;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      stop_err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      en_q         <= enable_word(state_q);
      tag_strobe_q <= strobe;
      tag_state_q  <= state_q;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;

      if (strobe) begin
        case (state_q)
          ST_START:  start_bit_q  <= sample;
          ST_DATA:   data_q       <= {sample, data_q[7:1]};
          ST_PARITY: parity_bit_q <= sample;
          ST_STOP:   stop_bit_q   <= sample;
          default:   ;
        endcase
      end

      if (state_q == ST_IDLE && fall) begin
        stop_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_q  <= 1'b0;
`endif
      end else begin
        if (stop_hit) stop_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
        if (par_hit) par_err_q <= 1'b1;
`endif
      end

      if (state_q == ST_START) bit_cnt_q <= '0;
      else if (state_q == ST_DATA && BIT_TICK) bit_cnt_q <= bit_cnt_q + 3'd1;

      // A stop error arriving together with the closing tick still counts.
      if (state_q == ST_STOP && BIT_TICK && !start_hit) begin
        if (stop_err_q || stop_hit) ferr_q  <= 1'b1;
        else if (par_flag)          perr_q  <= 1'b1;
        else                        valid_q <= 1'b1;
      end
    end
  end

  assign block_enable_word = en_q;
  assign start_bit         = start_bit_q;
  assign parity_bit        = parity_bit_q;
  assign stop_bit          = stop_bit_q;
  assign data_out          = data_q;
  assign data_valid        = valid_q;
  assign parity_error      = perr_q;
  assign framing_error     = ferr_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm; the bench plays the configuration block
// (strobes, ticks, checker flags) and predicts each frame's outcome from its bits.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in, par_en, BIT_TICK, sample_one_bit, sample_three_bit;
  logic [2:0] error_flag_word;
  logic [3:0] block_enable_word;
  logic       start_bit, parity_bit, stop_bit;
  logic [7:0] data_out;
  logic       data_valid, parity_error, framing_error;

  int vectors     = 0;
  int miscompares = 0;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx_fsm #(.SYNC_STAGES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_in             (rx_in),
    .par_en            (par_en),
    .BIT_TICK          (BIT_TICK),
    .sample_one_bit    (sample_one_bit),
    .sample_three_bit  (sample_three_bit),
    .error_flag_word   (error_flag_word),
    .block_enable_word (block_enable_word),
    .start_bit         (start_bit),
    .parity_bit        (parity_bit),
    .stop_bit          (stop_bit),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .parity_error      (parity_error),
    .framing_error     (framing_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle(input int n);
    rx_in = 1'b1; BIT_TICK = 1'b0; sample_one_bit = 1'b0; sample_three_bit = 1'b0;
    error_flag_word = 3'b000; par_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_en"},     32'(block_enable_word), 32'h0);
    check({tag, "_data"},   32'(data_out),          32'h00);
    check({tag, "_startb"}, 32'(start_bit),         32'h1);
    check({tag, "_parb"},   32'(parity_bit),        32'h0);
    check({tag, "_stopb"},  32'(stop_bit),          32'h1);
    check({tag, "_pulses"}, 32'({data_valid, parity_error, framing_error}), 32'h0);
  endtask

  // One frame with p cycles per bit (p >= 8); abort_c >= 0 asserts rst at that cycle.
  task automatic run_frame(input string tag, input logic [7:0] b, input int p, input bit par,
                           input bit force_perr, input bit stop_v, input int abort_c);
    logic     bits [0:10];
    int       nb, k_s, total, pulse_c, kk, ph, nv, np, nf;
    bit       eff_par, exp_dv, exp_pe, exp_fe;
    logic [1:0] sel;
    eff_par = par & PAR_BUILD;
    nb      = eff_par ? 11 : 10;
    k_s     = nb - 1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9]   = ^b;
    bits[10]  = 1'b1;
    bits[k_s] = stop_v;
    exp_fe  = !stop_v;
    exp_pe  = !exp_fe && eff_par && force_perr;
    exp_dv  = !exp_fe && !exp_pe;
    total   = nb * p + 8;
    pulse_c = nb * p + 2;
    nv = 0; np = 0; nf = 0;
    par_en = par;
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      rx_in = (c / p < nb) ? bits[c / p] : 1'b1;
      sample_one_bit = 1'b0; sample_three_bit = 1'b0; BIT_TICK = 1'b0; error_flag_word = 3'b000;
      if (c >= 2) begin
        kk = (c - 2) / p;
        ph = (c - 2) % p;
        if (kk < nb) begin
          if (ph == p / 2) begin
            sel = 2'($urandom_range(0, 2));
            sample_one_bit   = (sel != 2'd1);
            sample_three_bit = (sel != 2'd0);
          end
          if (ph == p / 2 + 1) begin
            if (kk == 0) error_flag_word[2] = bits[0];
            else if (eff_par && kk == 9) error_flag_word[1] = force_perr;
            else if (kk == k_s) error_flag_word[0] = ~bits[k_s];
          end
          if (ph == p - 1) BIT_TICK = 1'b1;
        end
      end
      if (c == abort_c) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset({tag, "_abort"});
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle(4);
        return;
      end
      @(negedge clk);
      if (data_valid === 1'b1) nv++;
      if (parity_error === 1'b1) np++;
      if (framing_error === 1'b1) nf++;
      if (c == 3) check({tag, "_en_idle"}, 32'(block_enable_word), 32'h0);
      if (c == 4) check({tag, "_en_start"}, 32'(block_enable_word), 32'hC);
      if (c == pulse_c)
        check({tag, "_pulse_at"}, 32'({data_valid, parity_error, framing_error}),
              32'({exp_dv, exp_pe, exp_fe}));
    end
    check({tag, "_n_valid"}, 32'(nv), 32'(exp_dv));
    check({tag, "_n_perr"},  32'(np), 32'(exp_pe));
    check({tag, "_n_ferr"},  32'(nf), 32'(exp_fe));
    check({tag, "_data"},    32'(data_out), 32'(b));
    check({tag, "_en_end"},  32'(block_enable_word), 32'h0);
    check({tag, "_startb"},  32'(start_bit), 32'h0);
    check({tag, "_stopb"},   32'(stop_bit), 32'(stop_v));
    if (eff_par) check({tag, "_parb"}, 32'(parity_bit), 32'(^b));
    drive_idle(4);
  endtask

  task automatic run_glitch(input int p);
    int   nv;
    logic lv;
    nv = 0;
    lv = (p / 2 < 2) ? 1'b0 : 1'b1;
    for (int c = 0; c < p + 12; c++) begin
      @(posedge clk); #1;
      rx_in = (c < 2) ? 1'b0 : 1'b1;
      sample_one_bit = (c == 2 + p / 2); sample_three_bit = 1'b0; BIT_TICK = 1'b0;
      error_flag_word = (c == 3 + p / 2) ? {lv, 2'b00} : 3'b000;
      @(negedge clk);
      if (data_valid === 1'b1 || parity_error === 1'b1 || framing_error === 1'b1) nv++;
      if (c == 4) check("glitch_en_start", 32'(block_enable_word), 32'hC);
      if (c == p / 2 + 5) check("glitch_en_back", 32'(block_enable_word), 32'h0);
    end
    check("glitch_pulses", 32'(nv), 32'h0);
    check("glitch_startb", 32'(start_bit), 32'(lv));
    drive_idle(4);
  endtask

  // Prescale 00: strobe and tick every cycle, start bit held two cycles, no idle gap.
  task automatic run_b2b(input logic [7:0] a, input logic [7:0] b2);
    logic line [0:21];
    logic [7:0] fb;
    int nv, ne;
    nv = 0; ne = 0;
    for (int f = 0; f < 2; f++) begin
      fb = (f == 0) ? a : b2;
      line[f*11]    = 1'b0;
      line[f*11+1]  = 1'b0;
      for (int i = 0; i < 8; i++) line[f*11+2+i] = fb[i];
      line[f*11+10] = 1'b1;
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      rx_in = (c < 22) ? line[c] : 1'b1;
      sample_one_bit = 1'b1; sample_three_bit = 1'b0; BIT_TICK = 1'b1; error_flag_word = 3'b000;
      @(negedge clk);
      if (data_valid === 1'b1) nv++;
      if (parity_error === 1'b1 || framing_error === 1'b1) ne++;
      if (c == 3)  check("b2b_en_idle", 32'(block_enable_word), 32'h0);
      if (c == 4)  check("b2b_en_start", 32'(block_enable_word), 32'hC);
      if (c == 13) check("b2b_first", 32'({data_valid, data_out}), 32'({1'b1, a}));
      if (c == 15) check("b2b_restart_en", 32'(block_enable_word), 32'hC);
      if (c == 24) check("b2b_second", 32'({data_valid, data_out}), 32'({1'b1, b2}));
    end
    check("b2b_n_valid", 32'(nv), 32'd2);
    check("b2b_n_err", 32'(ne), 32'd0);
    drive_idle(4);
  endtask

  function automatic int p_of(input int code);
    return 4 << code;
  endfunction

  initial begin
    rst = 1'b1;
    rx_in = 1'b1; par_en = 1'b0; BIT_TICK = 1'b0;
    sample_one_bit = 1'b0; sample_three_bit = 1'b0; error_flag_word = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle(4);

    run_frame("a5", 8'hA5, p_of(2), 1'b0, 1'b0, 1'b1, -1);
    run_frame("3c_par", 8'h3C, p_of(1), 1'b1, 1'b1, 1'b1, -1);
    run_frame("stop0", 8'($urandom), p_of(3), 1'b0, 1'b0, 1'b0, -1);
    run_glitch(p_of(2));
    run_b2b(8'h01, 8'hFE);
    run_frame("abort", 8'($urandom), p_of(2), 1'b0, 1'b0, 1'b1, 5 * p_of(2) + 4);
    check_reset("post_abort");
    run_frame("55", 8'h55, p_of($urandom_range(1, 3)), 1'b0, 1'b0, 1'b1, -1);

    for (int n = 0; n < 4; n++) begin
      logic [7:0] rb;
      int  code;
      bit  rpar, rforce, rstop;
      rb     = 8'($urandom);
      code   = $urandom_range(1, 3);
      rpar   = 1'($urandom_range(0, 1));
      rforce = rpar && ($urandom_range(0, 2) == 0);
      rstop  = ($urandom_range(0, 4) != 0);
      run_frame($sformatf("rand%0d", n), rb, p_of(code), rpar, rforce, rstop, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side frame controller and deserializer for the UART RX path. Synchronizes the serial line and detects the start edge. Samples each bit when the configuration block asserts its sample strobes, and shifts data LSB-first into the data register. Sequences the configuration block's sampler and checkers through `block_enable_word`, collects `error_flag_word`, and delivers received bytes with valid, parity-error and framing-error pulses.

## Interface
- `SYNC_STAGES`, 2: flops in the `rx_in` synchronizer (≥2).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_in` in 1: raw serial line, idle high.
- `par_en` in 1: parity bit present in frame.
- `BIT_TICK` in 1: end-of-bit strobe from the configuration block.
- `sample_one_bit` in 1: take the current synchronized sample.
- `sample_three_bit` in 1: take the majority of the last three synchronized samples.
- `error_flag_word` in 3: {start_err, parity_err, stop_err}.
- `block_enable_word` out 4: {sampler_en, start_en, parity_en, stop_en}.
- `start_bit`, `parity_bit`, `stop_bit` out 1: sampled frame bits.
- `data_out` out 8: deserialized data, LSB received first.
- `data_valid` out 1: one-cycle pulse when a good byte is complete.
- `parity_error` out 1: one-cycle pulse.
- `framing_error` out 1: one-cycle pulse.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `block_enable_word` = 4'b0000.
  - A synchronized falling edge on `rx_in` (previous 1, current 0) moves the FSM to START.
- **START**
  - Enable word = 4'b1100.
  - Each sample strobe loads `start_bit`.
  - When `start_err` is captured, return to IDLE with no outputs pulsed (glitch rejection).
  - `BIT_TICK` without an error moves the FSM to DATA and clears the bit counter.
- **DATA**
  - Enable word = 4'b1000.
  - Each sample strobe shifts the sample into `data_out[7]`, shifting right.
  - Each `BIT_TICK` increments the 3-bit bit counter.
  - `BIT_TICK` with counter == 7 moves the FSM to PARITY if `par_en`, otherwise to STOP.
- **PARITY**
  - Enable word = 4'b1010.
  - Sample strobes load `parity_bit`.
  - `BIT_TICK` moves the FSM to STOP.
  - A captured `parity_err` sets a sticky internal flag for the current frame.
- **STOP**
  - Enable word = 4'b1001.
  - Sample strobes load `stop_bit`.
  - `BIT_TICK` returns the FSM to IDLE and emits exactly one result pulse:
    - `framing_error` if `stop_err` was captured;
    - else `parity_error` if the sticky parity flag is set;
    - else `data_valid`.
- Sampling:
  - `sample_one_bit` uses the current synchronized bit.
  - `sample_three_bit` uses the majority of a 3-deep history shift register, updated every cycle.
  - If both strobes assert, `sample_three_bit` wins.
- Error capture:
  - `error_flag_word` is valid one cycle after a sample strobe.
  - The block registers a one-cycle-delayed copy of {strobe, state}.
  - An error bit is honoured only when that delayed tag matches the checker's state.
  - This works even when the state has already advanced (prescale 00, where `BIT_TICK` and the sample strobe are high every cycle).
- `rst` mid-frame:
  - Immediate return to IDLE.
  - All outputs cleared.
  - No pulse emitted.

## Timing
- Reset values:
  - `block_enable_word` = 0.
  - `data_out` = 8'h00.
  - `start_bit` = 1, `parity_bit` = 0, `stop_bit` = 1.
  - All pulses = 0.
  - Synchronizer and history register = all ones.
- Edge-detect latency: start edge to START entry = `SYNC_STAGES` + 1 cycles.
- Enable-word timing: `block_enable_word` is registered and changes the cycle after the state transition.
- Result pulse: asserted the cycle after the STOP-state `BIT_TICK`.
  - `data_out` is stable from that pulse until the next frame's first DATA sample.
- Back-to-back frames: a falling edge seen in the cycle of IDLE entry starts a new frame with no idle bit required.
- Late error: a `stop_err` arriving in the same cycle as the STOP exit still selects `framing_error`.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - PARITY state present.
  - `par_en` honoured.
  - `parity_error` can pulse.
- Undefined:
  - PARITY state and sticky flag removed.
  - `par_en` ignored; DATA always goes to STOP.
  - `parity_en` bit tied 0.
  - `parity_bit` held 0.
  - `parity_error` tied 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum;
  - enable-word bit indices (SAMPLER=3, START=2, PARITY=1, STOP=0);
  - error-word bit indices (START=2, PARITY=1, STOP=0);
  - prescale codes (00 none, 01 ×8, 10 ×16, 11 ×32).
- Sub-module `uart_rx_bit_sampler`:
  - synchronizer;
  - falling-edge detect;
  - 3-sample history;
  - majority vote;
  - strobe selection.
- The FSM, shift register and error-capture logic stay in `uart_rx_fsm`.

## Test plan
- Byte 0xA5, prescale 10, `par_en`=0, clean line -> `data_out`=8'hA5 and one `data_valid` pulse; `parity_error` and `framing_error` stay 0.
- Byte 0x3C, even parity, prescale 01, `parity_err` forced on the PARITY sample -> one `parity_error` pulse, no `data_valid`.
- Stop bit driven 0, prescale 11 -> one `framing_error` pulse; FSM in IDLE; enable word 0.
- `rx_in` low for 2 cycles only (glitch), prescale 10, `start_err` returned -> FSM back in IDLE, no pulses, enable word 0 within 2 cycles.
- Prescale 00, two back-to-back frames 0x01 then 0xFE -> two `data_valid` pulses with the matching `data_out` values.
- `rst` asserted during DATA bit 4 -> all outputs at reset values next edge; a following frame 0x55 received correctly.
